// File: rtl/quire_lzc_seq_pkg.sv
// posit_defines: shared state type for the sequential quire leading-zero counter
package posit_defines;
  typedef enum logic [1:0] {LZC_IDLE, LZC_SCAN, LZC_DONE} lzc_seq_state_t;
endpackage

// File: rtl/quire_lzc_seq_lod.sv
// lod_n: leading-zero count of a C_N-bit slice; x -> lz (result meaningful only when x != 0)
module lod_n #(
  parameter int C_N = 64
) (
  input  logic [C_N-1:0]         x,
  output logic [$clog2(C_N)-1:0] lz
);
  localparam int C_LW = $clog2(C_N);
  always_comb begin
    lz = '0;
    for (int i = 0; i < C_N; i++) if (x[i]) lz = C_LW'(C_N - 1 - i);
  end
endmodule

// File: rtl/quire_lzc_seq.sv
// quire_lzc_seq: MSB-first sliced leading-zero counter; in_valid/in_ready/in_data in, out_valid/out_ready/out_lzc/out_zero out, busy
module quire_lzc_seq
  import posit_defines::*;
#(
  parameter int C_W     = 512,
  parameter int C_CHUNK = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [C_W-1:0]           in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(C_W):0]     out_lzc,
  output logic                     out_zero,
  output logic                     busy
);
  localparam int C_NCHUNK = C_W / C_CHUNK;
  localparam int C_LZW    = $clog2(C_W) + 1;
  localparam int C_CW     = C_NCHUNK > 1 ? $clog2(C_NCHUNK) : 1;
  localparam int C_LW     = $clog2(C_CHUNK);
  if (C_W % C_CHUNK != 0) begin : g_bad_w
    $error("quire_lzc_seq: C_W must be a multiple of C_CHUNK");
  end
  if (C_CHUNK < 2 || (C_CHUNK & (C_CHUNK - 1)) != 0) begin : g_bad_chunk
    $error("quire_lzc_seq: C_CHUNK must be a power of two, at least 2");
  end
  lzc_seq_state_t   state, nxt;
  logic [C_W-1:0]   sr;
  logic [C_CW-1:0]  cnt;
  logic [C_LZW-1:0] acc;
  logic [C_LW-1:0]  lod;
  logic             nz, last;
  lod_n #(.C_N(C_CHUNK)) u_lod (.x(sr[C_W-1 -: C_CHUNK]), .lz(lod));
  always_comb begin
    nz        = |sr[C_W-1 -: C_CHUNK];
    last      = cnt == C_CW'(C_NCHUNK - 1);
    in_ready  = state == LZC_IDLE && !rst;
    out_valid = state == LZC_DONE;
    busy      = state != LZC_IDLE;
    nxt       = state == LZC_IDLE ? (in_valid ? LZC_SCAN : LZC_IDLE) :
                state == LZC_SCAN ? (nz || last ? LZC_DONE : LZC_SCAN) :
                                    (out_ready ? LZC_IDLE : LZC_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LZC_IDLE;
      sr       <= '0;
      cnt      <= '0;
      acc      <= '0;
      out_lzc  <= '0;
      out_zero <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LZC_IDLE && in_valid) begin
        sr  <= in_data;
        cnt <= '0;
        acc <= '0;
      end else if (state == LZC_SCAN) begin
        if (nz) begin
          out_lzc  <= acc + C_LZW'(lod);
          out_zero <= 1'b0;
        end else if (!last) begin
          sr  <= sr << C_CHUNK;
          acc <= acc + C_LZW'(C_CHUNK);
          cnt <= cnt + 1'b1;
        end else begin
          out_lzc  <= C_LZW'(C_W);
          out_zero <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_quire_lzc_seq.sv
// tb_quire_lzc_seq: self-checking bench for quire_lzc_seq with C_W=256, C_CHUNK=64
module tb_quire_lzc_seq;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [8:0]   out_lzc;
  logic         out_zero;
  logic         busy;
  int           n_chk = 0;
  int           n_fail = 0;
  quire_lzc_seq #(.C_W(256), .C_CHUNK(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lzc(out_lzc), .out_zero(out_zero), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic int ref_lz(input logic [255:0] d);
    for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
    return 256;
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic test_op(input logic [255:0] d, input int stall, input string nm);
    int n, lz, lat;
    lz  = ref_lz(d);
    lat = lz == 256 ? 5 : 2 + lz / 64;
    out_ready = stall == 0;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready_wait: got %b want 1", nm, in_ready); end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (n !== lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat); end
    n_chk++;
    if (out_lzc !== 9'(lz)) begin n_fail++; $display("FAIL %s lzc: got %0d want %0d", nm, out_lzc, lz); end
    n_chk++;
    if (out_zero !== (lz == 256)) begin n_fail++; $display("FAIL %s zero: got %b want %b", nm, out_zero, lz == 256); end
    for (int i = 0; i < stall; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_lzc !== 9'(lz) || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL %s stall%0d: valid=%b lzc=%0d rdy=%b want 1/%0d/0", nm, i, out_valid, out_lzc, in_ready, lz); end
      in_valid = 1'b1;
      in_data  = rnd256();
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_lzc !== 9'(lz))
      begin n_fail++; $display("FAIL %s hs_cycle: valid=%b lzc=%0d want 1/%0d", nm, out_valid, out_lzc, lz); end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL %s after_hs: valid=%b rdy=%b busy=%b want 0/1/0", nm, out_valid, in_ready, busy); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready, out_valid, busy, out_zero} !== 4'b0 || out_lzc !== 9'd0)
      begin n_fail++; $display("FAIL reset: rdy=%b valid=%b busy=%b zero=%b lzc=%0d want all 0", in_ready, out_valid, busy, out_zero, out_lzc); end
    rst = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release: in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_basic();
    test_op(256'(1) << 255, 0, "msb");
    test_op(256'(1) << 100, 0, "bit100");
    test_op('0, 0, "allzero");
  endtask
  task automatic test_stall();
    test_op(256'(1), 3, "lsb_stall");
  endtask
  task automatic test_reset_abort();
    in_valid = 1'b1;
    in_data  = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL abort: valid=%b busy=%b rdy=%b want 0/0/0", out_valid, busy, in_ready); end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL abort_idle: valid=%b busy=%b want 0/0", out_valid, busy); end
    end
    test_op(256'(1) << 200, 0, "after_abort");
  endtask
  task automatic test_back_to_back();
    logic [255:0] w [3];
    int n, lz, lat;
    w[0] = 256'(1) << 255;
    w[1] = 256'(1) << 191;
    w[2] = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w[0];
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    for (int j = 0; j < 3; j++) begin
      lz  = ref_lz(w[j]);
      lat = lz == 256 ? 5 : 2 + lz / 64;
      @(posedge clk); #1;
      if (j < 2) in_data = w[j+1];
      else in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (n !== lat || out_lzc !== 9'(lz))
        begin n_fail++; $display("FAIL b2b%0d: lat=%0d lzc=%0d want %0d/%0d", j, n, out_lzc, lat, lz); end
      @(posedge clk); #1;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        begin n_fail++; $display("FAIL b2b%0d_accept: rdy=%b valid=%b want 1/0", j, in_ready, out_valid); end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++)
      test_op(rnd256() >> $urandom_range(0, 256), int'($urandom_range(0, 2)), "random");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
